// File: rtl/muldiv_seq_pkg.sv
// Shared op codes, FSM encodings and widths for the iterative
// multiply/divide sequencer.
package muldiv_seq_pkg;

    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_MULH = 2'd1,
        MD_DIV  = 2'd2,
        MD_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_CALC = 2'd1,
        MDS_FIX  = 2'd2,
        MDS_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the mul/div
// sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    import muldiv_seq_pkg::*;

    logic            start_i;
    md_op_e          op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_seq_step.sv
// One combinational iteration: shift-add multiply or restoring
// divide over a shared 2*XLEN accumulator.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic              q_bit
);

    localparam int W2 = 2 * XLEN;

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, acc[W2-1:XLEN]}
               + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh = acc[W2-1:XLEN-1];
        diff   = rem_sh - {1'b0, opnd};
        q_bit  = 1'b0;
        acc_nxt = {sum, acc[XLEN-1:1]};
        if (is_div) begin
            q_bit = ~diff[XLEN];
            // quotient slot is left open; the caller inserts q_bit
            acc_nxt = {(q_bit ? diff[XLEN-1:0]
                              : rem_sh[XLEN-1:0]),
                       acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed MUL/MULH/DIV/REM sequencer that stalls EX
// through busy_o until the result is ready.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    muldiv_seq_if.slave  md
);
    import muldiv_seq_pkg::*;

    localparam int W2 = 2 * XLEN;

    md_state_e             state_q;
    md_state_e             state_d;
    md_op_e                op_q;
    logic                  s1_q;
    logic                  s2_q;
    logic [XLEN-1:0]       opnd_q;
    logic [W2-1:0]         acc_q;
    logic [MD_CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]       result_q;

    logic                  accept;
    logic                  div0;
    logic                  last;
    logic [XLEN-1:0]       mag1;
    logic [XLEN-1:0]       mag2;
    logic [W2-1:0]         step_acc;
    logic [W2-1:0]         acc_d;
    logic                  q_bit;
    logic [W2-1:0]         prod;
    logic [XLEN-1:0]       quo;
    logic [XLEN-1:0]       rem;
    logic [XLEN-1:0]       fix_res;

    assign mag1 = md.rs1_i[XLEN-1] ? -md.rs1_i : md.rs1_i;
    assign mag2 = md.rs2_i[XLEN-1] ? -md.rs2_i : md.rs2_i;

    assign accept = (state_q == MDS_IDLE)
                  && md.start_i && !md.flush_i;
    assign div0   = md.op_i[1] && (md.rs2_i == '0);
    assign last   = (cnt_q == MD_CNT_W'(XLEN - 1));

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div  (op_q[1]),
        .acc     (acc_q),
        .opnd    (opnd_q),
        .acc_nxt (step_acc),
        .q_bit   (q_bit)
    );

    assign acc_d = {step_acc[W2-1:1], step_acc[0] | q_bit};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= MDS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MDS_IDLE: begin
                if (accept) begin
                    state_d = div0 ? MDS_DONE : MDS_CALC;
                end
            end
            MDS_CALC: begin
                if (md.flush_i) begin
                    state_d = MDS_IDLE;
                end else if (last) begin
                    state_d = MDS_FIX;
                end
            end
            MDS_FIX: begin
                state_d = md.flush_i ? MDS_IDLE : MDS_DONE;
            end
            MDS_DONE: begin
                state_d = MDS_IDLE;
            end
            default: state_d = MDS_IDLE;
        endcase
    end

    // Sign fix-up from the magnitude results held in acc_q
    always_comb begin
        prod    = (s1_q ^ s2_q) ? -acc_q : acc_q;
        quo     = (s1_q ^ s2_q) ? -acc_q[XLEN-1:0]
                                : acc_q[XLEN-1:0];
        rem     = s1_q ? -acc_q[W2-1:XLEN]
                       : acc_q[W2-1:XLEN];
        fix_res = prod[XLEN-1:0];
        unique case (1'b1)
            (op_q == MD_MUL):  fix_res = prod[XLEN-1:0];
            (op_q == MD_MULH): fix_res = prod[W2-1:XLEN];
            (op_q == MD_DIV):  fix_res = quo;
            (op_q == MD_REM):  fix_res = rem;
            default:           fix_res = prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q     <= MD_MUL;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                MDS_IDLE: begin
                    if (accept) begin
                        op_q  <= md.op_i;
                        s1_q  <= md.rs1_i[XLEN-1];
                        s2_q  <= md.rs2_i[XLEN-1];
                        cnt_q <= '0;
                        if (md.op_i[1]) begin
                            opnd_q <= mag2;
                            acc_q  <= {{XLEN{1'b0}}, mag1};
                        end else begin
                            opnd_q <= mag1;
                            acc_q  <= {{XLEN{1'b0}}, mag2};
                        end
                        if (div0) begin
                            result_q <= (md.op_i == MD_DIV)
                                      ? '1 : md.rs1_i;
                        end
                    end
                end
                MDS_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + MD_CNT_W'(1);
                end
                MDS_FIX: begin
                    if (!md.flush_i) begin
                        result_q <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.busy_o   = accept
                       || (state_q == MDS_CALC)
                       || (state_q == MDS_FIX);
    assign md.done_o   = (state_q == MDS_DONE);
    assign md.result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors, expected
// results queued at issue and checked when done_o appears.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    muldiv_seq_if #(.XLEN(32)) md();

    muldiv_seq #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .md    (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && md.done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %h",
                         md.result_o);
            end else begin
                chk("result", md.result_o, exp_q.pop_front());
            end
        end
    end

    task automatic wait_done(input int lat, input int poke);
        int  cyc;
        bit  seen;
        bit  busy_ok;
        cyc = 0;
        seen = 0;
        busy_ok = 1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            md.start_i = 1'b0;
            md.flush_i = 1'b0;
            if (cyc == poke) begin
                md.start_i = 1'b1;
                md.op_i    = MD_MUL;
                md.rs1_i   = 32'd1;
                md.rs2_i   = 32'd1;
            end
            if (md.done_o) begin
                seen = 1;
                if (md.busy_o) busy_ok = 0;
            end else if (!md.busy_o) begin
                busy_ok = 0;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", cyc, lat);
        chk("busy_window", 32'(busy_ok), 32'd1);
        @(negedge clk);
        md.start_i = 1'b0;
        chk("idle_after_done",
            {30'd0, md.done_o, md.busy_o}, 32'd0);
    endtask

    task automatic issue(input md_op_e op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp,
                         input int lat,
                         input int poke);
        @(negedge clk);
        md.op_i    = op;
        md.rs1_i   = a;
        md.rs2_i   = b;
        md.start_i = 1'b1;
        md.flush_i = 1'b0;
        exp_q.push_back(exp);
        last_res = exp;
        #1;
        chk("busy_accept", 32'(md.busy_o), 32'd1);
        wait_done(lat, poke);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        last_res = '0;
        rst_n = 1'b0;
        md.start_i = 1'b0;
        md.flush_i = 1'b0;
        md.op_i    = MD_MUL;
        md.rs1_i   = '0;
        md.rs2_i   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(md.busy_o), 32'd0);
        chk("rst_done", 32'(md.done_o), 32'd0);
        chk("rst_result", md.result_o, 32'd0);
        rst_n = 1'b1;

        issue(MD_MUL,  32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 5);
        issue(MD_MULH, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, -1);
        issue(MD_MULH, 32'h80000000, 32'h80000000,
              32'h40000000, 34, -1);
        issue(MD_MUL,  32'h80000000, 32'h80000000,
              32'h00000000, 34, -1);
        issue(MD_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, -1);
        issue(MD_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, -1);
        issue(MD_DIV,  32'h80000000, 32'hFFFFFFFF,
              32'h80000000, 34, -1);
        issue(MD_REM,  32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 34, -1);
        issue(MD_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34, -1);
        issue(MD_REM,  32'd100, 32'hFFFFFFF9, 32'd2, 34, -1);
        issue(MD_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1, -1);
        issue(MD_REM,  32'd5, 32'd0, 32'd5, 1, -1);
        issue(MD_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, -1);

        // flush and start together in IDLE: nothing accepted
        @(negedge clk);
        md.op_i    = MD_DIV;
        md.rs1_i   = 32'd9;
        md.rs2_i   = 32'd0;
        md.start_i = 1'b1;
        md.flush_i = 1'b1;
        #1;
        chk("flush_start_busy", 32'(md.busy_o), 32'd0);
        @(negedge clk);
        md.start_i = 1'b0;
        md.flush_i = 1'b0;
        chk("flush_start_done", 32'(md.done_o), 32'd0);
        chk("flush_start_res", md.result_o, last_res);

        // flush in CALC at cycle 10, new start at cycle 11
        @(negedge clk);
        md.op_i    = MD_DIV;
        md.rs1_i   = 32'd100;
        md.rs2_i   = 32'd3;
        md.start_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            md.start_i = 1'b0;
        end
        md.flush_i = 1'b1;
        #1;
        chk("flush_busy_c10", 32'(md.busy_o), 32'd1);
        @(negedge clk);
        md.flush_i = 1'b0;
        chk("flush_idle_busy", 32'(md.busy_o), 32'd0);
        chk("flush_no_done", 32'(md.done_o), 32'd0);
        chk("flush_res_kept", md.result_o, last_res);
        md.op_i    = MD_MUL;
        md.rs1_i   = 32'd6;
        md.rs2_i   = 32'd7;
        md.start_i = 1'b1;
        exp_q.push_back(32'd42);
        last_res = 32'd42;
        #1;
        chk("restart_busy", 32'(md.busy_o), 32'd1);
        wait_done(34, -1);

        // reset in the middle of a multiply
        @(negedge clk);
        md.op_i    = MD_MUL;
        md.rs1_i   = 32'h00012345;
        md.rs2_i   = 32'd3;
        md.start_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            md.start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(md.busy_o), 32'd0);
        chk("midrst_done", 32'(md.done_o), 32'd0);
        chk("midrst_result", md.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(MD_MUL, 32'h00012345, 32'd3, 32'h000369CF, 34, -1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
